// File: rtl/fetch_pkg.sv
// Shared defaults and FSM state encoding for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_ADDR_W = 5;
   localparam int unsigned FETCH_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO with synchronous flush; head is always entry 0.
module fetch_fifo #(
   parameter int unsigned WIDTH = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] slot0, slot1;
   logic [1:0]       count;
   logic             do_push, do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign head    = slot0;
   assign do_push = push & !full;
   assign do_pop  = pop & !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b10: begin
               if (count == 2'd0) slot0 <= push_data;
               else               slot1 <= push_data;
               count <= count + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory address, and valid/ready output to decode.
// FETCH_FIFO_EN adds a 2-entry queue between memory capture and the output.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
   parameter int unsigned       DATA_W   = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0] START_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              busy
);

   fetch_state_e      state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic              capture;
   logic              flush;
   logic              slot_free;

   assign mem_addr = pc;
   assign busy     = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Priority in RUN: halt > redirect > advance.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      capture   = 1'b0;
      flush     = 1'b0;
      case (state)
         IDLE, HALTED: begin
            if (start) begin
               state_nxt = RUN;
               pc_nxt    = START_PC;
            end
         end
         RUN: begin
            if (halt) begin
               state_nxt = HALTED;
               flush     = 1'b1;
            end else if (redirect) begin
               pc_nxt = redirect_addr;
               flush  = 1'b1;
            end else if (slot_free) begin
               capture = 1'b1;
               pc_nxt  = pc + ADDR_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FETCH_FIFO_EN
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [DATA_W+ADDR_W-1:0] fifo_head;

   fetch_fifo #(
      .WIDTH(DATA_W + ADDR_W)
   ) u_fetch_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .push     (capture),
      .push_data({mem_rdata, pc}),
      .pop      (inst_valid & inst_ready),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (fifo_head)
   );

   assign slot_free            = !fifo_full;
   assign inst_valid           = !fifo_empty;
   assign {inst_data, inst_pc} = fifo_head;
`else
   assign slot_free = !inst_valid | inst_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_valid <= 1'b0;
         inst_data  <= '0;
         inst_pc    <= '0;
      end else if (flush) begin
         inst_valid <= 1'b0;
      end else if (capture) begin
         inst_valid <= 1'b1;
         inst_data  <= mem_rdata;
         inst_pc    <= pc;
      end
   end
`endif

endmodule
